// File: rtl/anita3_turf_pkg.sv
// Shared TURF buffer-manager types: FSM states, buffer codes and payload layout.
package anita3_turf_pkg;

  localparam int unsigned NBUF          = 4;
  localparam int unsigned BUF_W         = 2;
  localparam int unsigned SRC_W         = 4;
  localparam int unsigned CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } fsm_state_t;

  typedef enum logic [BUF_W-1:0] {
    BUF_A = 2'd0,
    BUF_B = 2'd1,
    BUF_C = 2'd2,
    BUF_D = 2'd3
  } buf_code_t;

  // Buffer/source pair presented to the event generator with digitize.
  typedef struct packed {
    logic [BUF_W-1:0] buffer;
    logic [SRC_W-1:0] source;
  } dig_info_t;

endpackage

// File: rtl/anita3_buffer_hold_manager_if.sv
// Trigger/clear/digitize/statistics bundle between trigger logic and the hold manager.
interface anita3_buffer_hold_manager_if #(
  parameter int unsigned CNT_WIDTH = anita3_turf_pkg::CNT_WIDTH_DEF
) ();

  logic                                trig_i;
  logic [anita3_turf_pkg::SRC_W-1:0]   trig_source_i;
  logic                                clear_i;
  logic [anita3_turf_pkg::BUF_W-1:0]   clear_buffer_i;
  logic                                clr_all_i;
  logic                                count_clear_i;
  logic                                digitize_o;
  logic [anita3_turf_pkg::BUF_W-1:0]   digitize_buffer_o;
  logic [anita3_turf_pkg::SRC_W-1:0]   digitize_source_o;
  logic [anita3_turf_pkg::NBUF-1:0]    buffer_status_o;
  logic                                deadtime_o;
  logic [CNT_WIDTH-1:0]                dead_count_o;
  logic [CNT_WIDTH-1:0]                drop_count_o;
  logic                                clear_err_o;

  modport master (
    output trig_i, trig_source_i, clear_i, clear_buffer_i, clr_all_i, count_clear_i,
    input  digitize_o, digitize_buffer_o, digitize_source_o, buffer_status_o,
           deadtime_o, dead_count_o, drop_count_o, clear_err_o
  );

  modport slave (
    input  trig_i, trig_source_i, clear_i, clear_buffer_i, clr_all_i, count_clear_i,
    output digitize_o, digitize_buffer_o, digitize_source_o, buffer_status_o,
           deadtime_o, dead_count_o, drop_count_o, clear_err_o
  );

endinterface

// File: rtl/anita3_rr_pick4.sv
// Rotated priority encoder: first free (mask bit 0) buffer starting at ptr, wrapping mod 4.
module anita3_rr_pick4 (
  input  logic [3:0] mask,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest free buffer wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (!mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/anita3_buffer_hold_manager.sv
// Allocates the four TURF digitizer buffers to triggers, tracks holds and reports
// deadtime/drop statistics.
module anita3_buffer_hold_manager
  import anita3_turf_pkg::*;
#(
  parameter int unsigned DIG_CYCLES     = 4,
  parameter int unsigned HOLDOFF_CYCLES = 8,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                  clk125_i,
  input  logic                  rst_i,
  anita3_buffer_hold_manager_if.slave bus
);

  localparam int unsigned TMR_MAX = (DIG_CYCLES > HOLDOFF_CYCLES) ? DIG_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  fsm_state_t           state, state_nxt;
  logic [TMR_W-1:0]     tmr, tmr_nxt;
  logic [NBUF-1:0]      mask, mask_nxt;
  logic [BUF_W-1:0]     rr, rr_nxt;
  logic                 clear_err, clear_err_nxt;
  logic [CNT_WIDTH-1:0] dead_cnt, dead_cnt_nxt;
  logic [CNT_WIDTH-1:0] drop_cnt, drop_cnt_nxt;
  logic                 digitize, deadtime;
  dig_info_t            dig_info;
  logic                 found, accept, drop;
  logic [BUF_W-1:0]     pick;

  anita3_rr_pick4 u_pick (
    .mask  (mask),
    .ptr   (rr),
    .found (found),
    .idx   (pick)
  );

  // Next-state: FSM timing, allocation, clears, then clr_all override.
  always_comb begin
    state_nxt     = state;
    tmr_nxt       = tmr;
    mask_nxt      = mask;
    rr_nxt        = rr;
    clear_err_nxt = clear_err;
    accept        = 1'b0;
    drop          = 1'b0;

    case (state)
      IDLE: begin
        if (bus.trig_i) begin
          accept = found;
          drop   = !found;
        end
      end
      ISSUE: begin
        drop = bus.trig_i;
        if (tmr == TMR_W'(DIG_CYCLES - 1)) begin
          state_nxt = HOLDOFF;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      HOLDOFF: begin
        drop = bus.trig_i;
        if (tmr == TMR_W'(HOLDOFF_CYCLES - 1)) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tmr_nxt   = '0;
      end
    endcase

    if (accept) begin
      state_nxt      = ISSUE;
      tmr_nxt        = '0;
      mask_nxt[pick] = 1'b1;
      rr_nxt         = pick + 2'd1;
    end

    // A buffer freed here only becomes allocatable next cycle: pick used the old mask.
    if (bus.clear_i) begin
      if (mask[bus.clear_buffer_i]) mask_nxt[bus.clear_buffer_i] = 1'b0;
      else                          clear_err_nxt                = 1'b1;
    end

    if (bus.clr_all_i) begin
      state_nxt     = IDLE;
      tmr_nxt       = '0;
      mask_nxt      = '0;
      rr_nxt        = BUF_A;
      clear_err_nxt = 1'b0;
      accept        = 1'b0;
      drop          = 1'b0;
    end

    dead_cnt_nxt = dead_cnt;
    drop_cnt_nxt = drop_cnt;
    if (deadtime && !(&dead_cnt)) dead_cnt_nxt = dead_cnt + CNT_WIDTH'(1);
    if (drop && !(&drop_cnt))     drop_cnt_nxt = drop_cnt + CNT_WIDTH'(1);
    if (bus.count_clear_i) begin
      dead_cnt_nxt = '0;
      drop_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk125_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tmr       <= '0;
      mask      <= '0;
      rr        <= BUF_A;
      clear_err <= 1'b0;
      dead_cnt  <= '0;
      drop_cnt  <= '0;
      digitize  <= 1'b0;
      deadtime  <= 1'b0;
      dig_info  <= '0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      mask      <= mask_nxt;
      rr        <= rr_nxt;
      clear_err <= clear_err_nxt;
      dead_cnt  <= dead_cnt_nxt;
      drop_cnt  <= drop_cnt_nxt;
      digitize  <= (state_nxt == ISSUE);
      deadtime  <= &mask_nxt;
      if (accept) begin
        dig_info.buffer <= pick;
        dig_info.source <= bus.trig_source_i;
      end
    end
  end

  assign bus.digitize_o        = digitize;
  assign bus.digitize_buffer_o = dig_info.buffer;
  assign bus.digitize_source_o = dig_info.source;
  assign bus.buffer_status_o   = mask;
  assign bus.deadtime_o        = deadtime;
  assign bus.dead_count_o      = dead_cnt;
  assign bus.drop_count_o      = drop_cnt;
  assign bus.clear_err_o       = clear_err;

endmodule

// File: tb/tb_anita3_buffer_hold_manager.sv
// Self-checking bench: directed scenarios plus random traffic against a timestamp-based
// model of buffer holds, allocation order and statistics.
module tb_anita3_buffer_hold_manager;

  localparam int DIG  = 4;
  localparam int HOLD = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  anita3_buffer_hold_manager_if #(.CNT_WIDTH(CW)) bus ();

  anita3_buffer_hold_manager #(
    .DIG_CYCLES     (DIG),
    .HOLDOFF_CYCLES (HOLD),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk125_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cycle stamps for the digitize window and next-accept time, plus the held set.
  int         cyc, acc_cyc, ready_cyc, m_rr, m_buf, m_src, m_dead, m_drop;
  logic [3:0] m_mask;
  bit         m_err, m_deadflag;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; acc_cyc = -1000; ready_cyc = 0; m_rr = 0; m_buf = 0; m_src = 0;
    m_dead = 0; m_drop = 0; m_mask = 4'h0; m_err = 1'b0; m_deadflag = 1'b0;
  endtask

  task automatic check_all();
    bit dig_exp;
    dig_exp = (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + DIG);
    check_eq("digitize", 32'(bus.digitize_o), 32'(dig_exp));
    check_eq("status", 32'(bus.buffer_status_o), 32'(m_mask));
    check_eq("deadtime", 32'(bus.deadtime_o), 32'(m_deadflag));
    check_eq("dead_count", 32'(bus.dead_count_o), 32'(m_dead));
    check_eq("drop_count", 32'(bus.drop_count_o), 32'(m_drop));
    check_eq("clear_err", 32'(bus.clear_err_o), 32'(m_err));
    if (dig_exp) begin
      check_eq("dig_buffer", 32'(bus.digitize_buffer_o), 32'(m_buf));
      check_eq("dig_source", 32'(bus.digitize_source_o), 32'(m_src));
    end
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, check outputs.
  task automatic step(input bit t, input logic [3:0] src, input bit c, input logic [1:0] cb,
                      input bit ca, input bit cc);
    logic [3:0] nm;
    bit         got_one;
    bus.trig_i = t; bus.trig_source_i = src; bus.clear_i = c; bus.clear_buffer_i = cb;
    bus.clr_all_i = ca; bus.count_clear_i = cc;
    @(posedge clk);
    if (m_deadflag && m_dead < CMAX) m_dead++;
    if (ca) begin
      m_mask = 4'h0; m_rr = 0; m_err = 1'b0; acc_cyc = -1000; ready_cyc = cyc + 1;
    end else begin
      nm = m_mask;
      got_one = 1'b0;
      if (t) begin
        if (cyc >= ready_cyc && m_mask != 4'hF) begin
          for (int i = 0; i < 4; i++) begin
            if (!got_one && !m_mask[(m_rr + i) % 4]) begin
              got_one = 1'b1;
              m_buf   = (m_rr + i) % 4;
            end
          end
          nm[m_buf] = 1'b1;
          m_rr      = (m_buf + 1) % 4;
          m_src     = int'(src);
          acc_cyc   = cyc;
          ready_cyc = cyc + DIG + HOLD + 1;
        end else if (m_drop < CMAX) begin
          m_drop++;
        end
      end
      if (c) begin
        if (m_mask[cb]) nm[cb] = 1'b0;
        else            m_err  = 1'b1;
      end
      m_mask = nm;
    end
    if (cc) begin
      m_dead = 0; m_drop = 0;
    end
    m_deadflag = (m_mask == 4'hF);
    cyc++;
    #1;
    check_all();
    bus.trig_i = 1'b0; bus.clear_i = 1'b0; bus.clr_all_i = 1'b0; bus.count_clear_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic trig(input logic [3:0] src);
    step(1'b1, src, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic clear(input logic [1:0] b);
    step(1'b0, 4'h0, 1'b1, b, 1'b0, 1'b0);
  endtask

  initial begin
    bus.trig_i = 1'b0; bus.trig_source_i = 4'h0; bus.clear_i = 1'b0;
    bus.clear_buffer_i = 2'd0; bus.clr_all_i = 1'b0; bus.count_clear_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_digitize", 32'(bus.digitize_o), 32'd0);
    check_eq("rst_status", 32'(bus.buffer_status_o), 32'd0);
    check_eq("rst_counts", 32'({bus.dead_count_o, bus.drop_count_o}), 32'd0);
    rst = 1'b0;

    // Single trigger: 4-cycle strobe on buffer 0, next accept 13 cycles later.
    trig(4'h5);
    check_eq("t1_buf", 32'(bus.digitize_buffer_o), 32'd0);
    check_eq("t1_status", 32'(bus.buffer_status_o), 32'h1);
    idle(11);
    trig(4'h6);
    check_eq("t1_early_drop", 32'(bus.drop_count_o), 32'd1);
    trig(4'h7);
    check_eq("t1_accept13", 32'(bus.digitize_o), 32'd1);
    check_eq("t1_buf2", 32'(bus.digitize_buffer_o), 32'd1);

    // Four spaced triggers fill A..D; a fifth is dropped.
    step(1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      trig(4'(k + 8));
      check_eq("t2_order", 32'(bus.digitize_buffer_o), 32'(k));
      idle(13);
    end
    check_eq("t2_full", 32'(bus.buffer_status_o), 32'hF);
    check_eq("t2_dead", 32'(bus.deadtime_o), 32'd1);
    trig(4'h3);
    check_eq("t2_drop", 32'(bus.drop_count_o), 32'd1);
    check_eq("t2_nodig", 32'(bus.digitize_o), 32'd0);

    // Clear and trigger together while full: trigger dropped, freed buffer used next cycle.
    step(1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 1'b0);
    check_eq("t3_drop", 32'(bus.drop_count_o), 32'd2);
    check_eq("t3_status", 32'(bus.buffer_status_o), 32'hB);
    trig(4'h9);
    check_eq("t3_buf", 32'(bus.digitize_buffer_o), 32'd2);

    // rr_ptr now 3; free A..C so only D is held, next allocation wraps to A.
    idle(13);
    clear(2'd0); clear(2'd1); clear(2'd2);
    check_eq("t4_mask", 32'(bus.buffer_status_o), 32'h8);
    trig(4'hA);
    check_eq("t4_wrap", 32'(bus.digitize_buffer_o), 32'd0);
    clear(2'd1);
    check_eq("t4_err", 32'(bus.clear_err_o), 32'd1);

    // clr_all in the second ISSUE cycle.
    idle(13);
    trig(4'hC);
    idle(1);
    step(1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    check_eq("t5_dig", 32'(bus.digitize_o), 32'd0);
    check_eq("t5_status", 32'(bus.buffer_status_o), 32'd0);
    check_eq("t5_err", 32'(bus.clear_err_o), 32'd0);
    trig(4'hD);
    check_eq("t5_restart", 32'(bus.digitize_buffer_o), 32'd0);

    // Dead counter saturation and clear.
    for (int k = 0; k < 3; k++) begin
      idle(13);
      trig(4'h1);
    end
    step(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(CMAX - 1);
    check_eq("t6_almost", 32'(bus.dead_count_o), 32'(CMAX - 1));
    idle(3);
    check_eq("t6_sat", 32'(bus.dead_count_o), 32'(CMAX));
    step(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    check_eq("t6_clr", 32'(bus.dead_count_o), 32'd0);

    // Async reset in the middle of ISSUE drops digitize immediately.
    step(1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    trig(4'h2);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_dig", 32'(bus.digitize_o), 32'd0);
    check_eq("arst_status", 32'(bus.buffer_status_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit         t, c, ca, cc;
      logic [1:0] cb;
      t  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 3) == 0);
      cb = 2'($urandom_range(0, 3));
      ca = ($urandom_range(0, 99) == 0);
      cc = ($urandom_range(0, 149) == 0);
      step(t, 4'($urandom_range(0, 15)), c, cb, ca, cc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
